ft_lane_voter: RTL
==================

# ft_lane_voter

Parametrised successor to the dual-core fault-tolerance front end. It compares register-file write-backs from 2 (DMR) or 3 (TMR) lock-stepped lanes and forwards a single voted write to the safe register copy. On a mismatch it sequences a per-lane reset/recover handshake. In TMR mode it masks a single faulty lane, identifies it, and resets only that lane; in DMR mode any mismatch resets all lanes.

## Interface
Parameters:
- NUM_LANES, 3, lane count; legal values 2 or 3 (elaboration error otherwise)
- ADDR_WIDTH, 5, register-file address width
- DATA_WIDTH, 32, write-back data width
- RST_CYCLES, 4, cycles `reset_no` is held low per recovery; must be ≥1
- CNT_WIDTH, 8, width of each per-lane error counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  comparison enable
- we_i  in  NUM_LANES  per-lane write enable
- addr_i  in  NUM_LANES*ADDR_WIDTH  per-lane address; lane k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_i  in  NUM_LANES*DATA_WIDTH  per-lane data, packed the same way
- done_i  in  1  recovery-complete strobe from the recovery routine
- safe_we_o  out  1  voted write enable
- safe_addr_o  out  ADDR_WIDTH  voted address
- safe_data_o  out  DATA_WIDTH  voted data
- error_o  out  1  one-cycle pulse for each detected mismatch
- uncorrectable_o  out  1  one-cycle pulse, coincident with `error_o`, when no majority exists
- faulty_lane_o  out  NUM_LANES  sticky mask of lanes being recovered
- reset_no  out  NUM_LANES  per-lane active-low core reset
- recover_o  out  1  debug/recovery request
- recovering_o  out  1  high while not in RUN
- lane_err_cnt_o  out  NUM_LANES*CNT_WIDTH  per-lane error counters

## Operation
- Lanes i and j agree when `we` matches and, if `we`=1, both `addr` and `data` match.
- **Full agreement:** forward lane 0's write.
- **TMR, exactly one lane disagreeing:** correctable.
  - Forward the majority pair's write.
  - Faulty lane is the outlier.
- **TMR, no pair agrees, or DMR with any disagreement:** uncorrectable.
  - Suppress `safe_we`.
  - Faulty mask is all lanes.
- **enable_i=0:** no comparison; lane 0's write is forwarded; no errors are raised.
- FSM states: RUN, RESET, RECOVER.
  - RUN: compare every cycle. On a mismatch (enable_i=1), pulse `error_o` (and `uncorrectable_o` if applicable), latch `faulty_lane_o`, load the reset counter with RST_CYCLES, and go to RESET.
  - RESET: `reset_no` is low on the bits set in `faulty_lane_o`. The counter decrements each cycle. At 0, go to RECOVER.
  - RECOVER: `recover_o`=1. When `done_i`=1 is sampled, clear `faulty_lane_o` and go to RUN.
- Outside RUN:
  - `safe_we_o` is forced to 0.
  - Comparison results are ignored.
  - `done_i` is ignored outside RECOVER.
- DMR correctable case does not exist; every DMR mismatch is uncorrectable.

## Timing
- Reset values:
  - `reset_no` = all ones.
  - Every other output = 0.
  - FSM = RUN.
  - Counters = 0.
- Safe write outputs are registered: lane inputs at cycle t appear on `safe_*_o` at t+1.
- Mismatch sampled at cycle t:
  - `error_o` and `uncorrectable_o` pulse at t+1.
  - `faulty_lane_o` is valid from t+1.
  - `reset_no` is low for cycles t+1 .. t+RST_CYCLES.
  - `recover_o` is high from t+RST_CYCLES+1.
  - `recovering_o` is high from t+1 until the cycle after `done_i` is sampled.
- `done_i` sampled high at cycle d in RECOVER: at d+1, `recover_o`=0, `recovering_o`=0, `faulty_lane_o`=0, and comparison resumes in RUN.
- `rst_ni` asserted mid-recovery: all state and outputs return to reset values immediately, asynchronously.
- A new mismatch during RESET/RECOVER is neither counted nor latched.

## Configuration
- `FT_LANE_ERR_CNT_EN` defined:
  - Each lane's counter increments by 1 in the cycle `error_o` pulses if that lane's bit is in the newly latched faulty mask.
  - Counters saturate at 2^CNT_WIDTH−1.
  - Counters clear only on `rst_ni`.
- Not defined: no counter flops; `lane_err_cnt_o` is tied to 0.

## Test plan
- TMR, all lanes write addr 3 / data 0xDEADBEEF: next cycle `safe_we_o`=1, addr 3, data 0xDEADBEEF; `error_o`=0.
- TMR, lane 2 data 0x1 vs 0x0 on others: `safe_data_o`=0x0 with `safe_we_o`=1; `faulty_lane_o`=3'b100; `reset_no`=3'b011 for 4 cycles; then `recover_o`=1; `done_i` pulse returns to RUN; counter for lane 2 = 1 (macro on).
- TMR, three distinct addresses: `safe_we_o`=0, `uncorrectable_o`=1, `reset_no`=3'b000 for RST_CYCLES.
- DMR (NUM_LANES=2), `we_i`=2'b01: uncorrectable; `faulty_lane_o`=2'b11; `recover_o` waits indefinitely until `done_i`.
- `rst_ni` dropped during RESET: `reset_no` returns to all ones, FSM is RUN, and counters are 0 in the same cycle.
- 300 lane-0 faults with CNT_WIDTH=8, with `done_i` strobed to complete each recovery: lane 0 counter saturates at 255; with the macro undefined, `lane_err_cnt_o` stays 0.

Source files
------------

// File: rtl/ft_lane_voter.sv
// Lock-step write-back voter for 2 (DMR) or 3 (TMR) lanes with per-lane reset/recover sequencing.
// Define FT_LANE_ERR_CNT_EN to build the saturating per-lane error counters.
module ft_lane_voter #(
    parameter int NUM_LANES  = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int RST_CYCLES = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic [NUM_LANES-1:0]            we_i,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
    input  logic                            done_i,
    output logic                            safe_we_o,
    output logic [ADDR_WIDTH-1:0]           safe_addr_o,
    output logic [DATA_WIDTH-1:0]           safe_data_o,
    output logic                            error_o,
    output logic                            uncorrectable_o,
    output logic [NUM_LANES-1:0]            faulty_lane_o,
    output logic [NUM_LANES-1:0]            reset_no,
    output logic                            recover_o,
    output logic                            recovering_o,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  lane_err_cnt_o
);
    localparam int RCW = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

    if (NUM_LANES != 2 && NUM_LANES != 3) begin : g_bad_lanes
        $error("ft_lane_voter: NUM_LANES must be 2 or 3");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("ft_lane_voter: RST_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {RUN, RESET, RECOVER} state_t;

    function automatic logic lanes_agree(input logic we_a, input logic we_b,
                                         input logic [ADDR_WIDTH-1:0] addr_a,
                                         input logic [ADDR_WIDTH-1:0] addr_b,
                                         input logic [DATA_WIDTH-1:0] data_a,
                                         input logic [DATA_WIDTH-1:0] data_b);
        return (we_a == we_b) && (!we_a || ((addr_a == addr_b) && (data_a == data_b)));
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        return (val == {CNT_WIDTH{1'b1}}) ? val : val + CNT_WIDTH'(1);
    endfunction

    logic [ADDR_WIDTH-1:0] lane_addr [NUM_LANES];
    logic [DATA_WIDTH-1:0] lane_data [NUM_LANES];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_unpack
        assign lane_addr[k] = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign lane_data[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    logic                  vote_we;
    logic [ADDR_WIDTH-1:0] vote_addr;
    logic [DATA_WIDTH-1:0] vote_data;
    logic                  vote_mis;
    logic                  vote_unc;
    logic [NUM_LANES-1:0]  vote_mask;

    if (NUM_LANES == 3) begin : g_tmr
        logic a01, a02, a12;
        assign a01 = lanes_agree(we_i[0], we_i[1], lane_addr[0], lane_addr[1], lane_data[0], lane_data[1]);
        assign a02 = lanes_agree(we_i[0], we_i[2], lane_addr[0], lane_addr[2], lane_data[0], lane_data[2]);
        assign a12 = lanes_agree(we_i[1], we_i[2], lane_addr[1], lane_addr[2], lane_data[1], lane_data[2]);

        // Agreement is transitive, so a single agreeing pair singles out the outlier.
        always_comb begin
            vote_we   = we_i[0];
            vote_addr = lane_addr[0];
            vote_data = lane_data[0];
            vote_mis  = 1'b0;
            vote_unc  = 1'b0;
            vote_mask = '0;
            if (!(a01 && a02 && a12)) begin
                vote_mis = 1'b1;
                if (a01) begin
                    vote_mask = 3'b100;
                end else if (a02) begin
                    vote_mask = 3'b010;
                end else if (a12) begin
                    vote_mask = 3'b001;
                    vote_we   = we_i[1];
                    vote_addr = lane_addr[1];
                    vote_data = lane_data[1];
                end else begin
                    vote_unc  = 1'b1;
                    vote_mask = '1;
                    vote_we   = 1'b0;
                end
            end
        end
    end else begin : g_dmr
        logic a01;
        assign a01 = lanes_agree(we_i[0], we_i[1], lane_addr[0], lane_addr[1], lane_data[0], lane_data[1]);

        always_comb begin
            vote_addr = lane_addr[0];
            vote_data = lane_data[0];
            vote_mis  = !a01;
            vote_unc  = !a01;
            vote_mask = a01 ? '0 : '1;
            vote_we   = a01 ? we_i[0] : 1'b0;
        end
    end

    state_t            state_q, state_d;
    logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [NUM_LANES-1:0] faulty_q, faulty_d;
    logic              err_d, unc_d;
    logic              err_q, unc_q;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        faulty_d  = faulty_q;
        err_d     = 1'b0;
        unc_d     = 1'b0;
        case (state_q)
            RUN: begin
                if (enable_i && vote_mis) begin
                    err_d     = 1'b1;
                    unc_d     = vote_unc;
                    faulty_d  = vote_mask;
                    rst_cnt_d = RCW'(RST_CYCLES);
                    state_d   = RESET;
                end
            end
            RESET: begin
                rst_cnt_d = rst_cnt_q - RCW'(1);
                if (rst_cnt_q <= RCW'(1)) state_d = RECOVER;
            end
            RECOVER: begin
                if (done_i) begin
                    faulty_d = '0;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            rst_cnt_q <= '0;
            faulty_q  <= '0;
            err_q     <= 1'b0;
            unc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            faulty_q  <= faulty_d;
            err_q     <= err_d;
            unc_q     <= unc_d;
        end
    end

    // Stage p0 -> p1: registered safe write; the write enable is only honoured while in RUN.
    logic                  safe_we_p1;
    logic [ADDR_WIDTH-1:0] safe_addr_p1;
    logic [DATA_WIDTH-1:0] safe_data_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            safe_we_p1   <= 1'b0;
            safe_addr_p1 <= '0;
            safe_data_p1 <= '0;
        end else begin
            safe_we_p1   <= (state_q == RUN) && (enable_i ? vote_we : we_i[0]);
            safe_addr_p1 <= enable_i ? vote_addr : lane_addr[0];
            safe_data_p1 <= enable_i ? vote_data : lane_data[0];
        end
    end

`ifdef FT_LANE_ERR_CNT_EN
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (err_d && faulty_d[k]) begin
                cnt_q <= sat_inc(cnt_q);
            end
        end
        assign lane_err_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`else
    assign lane_err_cnt_o = '0;
`endif

    assign safe_we_o       = safe_we_p1;
    assign safe_addr_o     = safe_addr_p1;
    assign safe_data_o     = safe_data_p1;
    assign error_o         = err_q;
    assign uncorrectable_o = unc_q;
    assign faulty_lane_o   = faulty_q;
    assign reset_no        = (state_q == RESET) ? ~faulty_q : '1;
    assign recover_o       = (state_q == RECOVER);
    assign recovering_o    = (state_q != RUN);

endmodule
